// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcodes, sequencer states, phase numbers and shared decode helpers
// for the VeriRisc instruction sequencer.
package veririsc_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    localparam logic [2:0] PH_ADDR    = 3'd0;
    localparam logic [2:0] PH_IR_LOAD = 3'd2;
    localparam logic [2:0] PH_IR_END  = 3'd3;
    localparam logic [2:0] PH_EXEC    = 3'd4;
    localparam logic [2:0] PH_OPERAND = 3'd5;
    localparam logic [2:0] PH_ALU     = 3'd6;
    localparam logic [2:0] PH_LAST    = 3'd7;

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        STEP_WAIT
    } state_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
    } ctrl_t;

    typedef struct packed {
        logic h;
        logic a;
        logic z;
        logic j;
        logic s;
    } terms_t;

    function automatic logic is_illegal(input logic [31:0] op);
        return op > 32'd7;
    endfunction

    // An out-of-range opcode kills every term, leaving only the fetch strobes.
    function automatic terms_t decode_terms(input logic [31:0] op, input logic zero);
        logic [2:0] o;
        logic       ok;
        o  = op[2:0];
        ok = !is_illegal(op);
        return '{h: ok && o == HLT,
                 a: ok && (o inside {ADD, AND, XOR, LDA}),
                 z: ok && o == SKZ && zero,
                 j: ok && o == JMP,
                 s: ok && o == STO};
    endfunction

endpackage

// File: rtl/veririsc_phase_decode.sv
// veririsc_phase_decode: combinational datapath control decode from
// (state, phase, opcode, zero); outside RUN only sel is driven.
module veririsc_phase_decode
    import veririsc_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  state_e              state,
    input  logic [2:0]          phase,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output ctrl_t               ctrl
);

    terms_t t;
    logic   run;

    assign t   = decode_terms(32'(opcode), zero);
    assign run = state == RUN;

    always_comb begin
        ctrl        = '0;
        ctrl.sel    = !run || phase <= PH_IR_END;
        ctrl.rd     = run && ((phase != PH_ADDR && phase <= PH_IR_END) || (phase >= PH_OPERAND && t.a));
        ctrl.ld_ir  = run && (phase inside {PH_IR_LOAD, PH_IR_END});
        ctrl.inc_pc = run && (phase == PH_EXEC || (phase == PH_ALU && t.z));
        ctrl.halt   = run && phase == PH_EXEC && t.h;
        ctrl.ld_pc  = run && phase >= PH_ALU && t.j;
        ctrl.data_e = run && phase >= PH_ALU && t.s;
        ctrl.ld_ac  = run && phase == PH_LAST && t.a;
        ctrl.wr     = run && phase == PH_LAST && t.s;
    end

endmodule

// File: rtl/veririsc_sequencer.sv
// veririsc_sequencer: 8-phase instruction cycle with run/halt/single-step control,
// memory wait states and a retired-instruction counter; illegal pulses the cycle after retirement.
module veririsc_sequencer
    import veririsc_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16,
    parameter bit WAIT_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                resume,
    input  logic                step_mode,
    input  logic                step,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr,
    output logic [2:0]          phase,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             stall, retire, leave;
    ctrl_t            ctrl;

    veririsc_phase_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state  (state_q),
        .phase  (phase_q),
        .opcode (opcode),
        .zero   (zero),
        .ctrl   (ctrl)
    );

    // ld_ac/wr are only ever high in phase 7 of a memory-operand instruction.
    always_comb begin
        stall     = WAIT_EN && !mem_ready && state_q == RUN
                    && (phase_q == PH_IR_END || ctrl.ld_ac || ctrl.wr);
        retire    = state_q == RUN && phase_q == PH_LAST && !stall;
        leave     = state_q == HALTED ? resume : state_q == STEP_WAIT ? (step || resume) : 1'b0;
        state_d   = ctrl.halt ? HALTED : (retire && step_mode) ? STEP_WAIT : leave ? RUN : state_q;
        phase_d   = (state_q != RUN || ctrl.halt || retire) ? 3'd0 : stall ? phase_q : phase_q + 3'd1;
        cnt_d     = cnt_q + CNT_W'(retire);
        illegal_d = retire && is_illegal(32'(opcode));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= RUN;
            phase_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = ctrl;
    assign phase       = phase_q;
    assign halted      = state_q == HALTED;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// tb_veririsc_sequencer: directed per-cycle scoreboard plus immediate checks on a 4-bit-opcode, 2-bit-counter DUT
module tb_veririsc_sequencer;
  localparam logic [8:0] F0 = 9'h100;
  localparam logic [8:0] F1 = 9'h180;
  localparam logic [8:0] F2 = 9'h1C0;
  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  opcode;
  logic        zero, mem_ready, resume, step_mode, step;
  logic        sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0]  phase;
  logic        halted, illegal;
  logic [1:0]  instr_count;
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] act;
  logic        exp_hl = 1'b0;
  logic        exp_il = 1'b0;
  logic [1:0]  exp_cnt = 2'd0;
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  veririsc_sequencer #(.OPCODE_W(4), .CNT_W(2), .WAIT_EN(1'b1)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .step_mode   (step_mode),
    .step        (step),
    .sel         (sel),
    .rd          (rd),
    .ld_ir       (ld_ir),
    .inc_pc      (inc_pc),
    .halt        (halt),
    .ld_pc       (ld_pc),
    .data_e      (data_e),
    .ld_ac       (ld_ac),
    .wr          (wr),
    .phase       (phase),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );
  assign act = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, halted, illegal, instr_count};
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++;
      if (act === e.v) n_pass++;
      else $display("FAIL %s: got ph=%0d ctl=%h hlt=%b ill=%b cnt=%0d, want ph=%0d ctl=%h hlt=%b ill=%b cnt=%0d",
                    e.nm, act[15:13], act[12:4], act[3], act[2], act[1:0],
                    e.v[15:13], e.v[12:4], e.v[3], e.v[2], e.v[1:0]);
    end
  end
  function automatic logic [8:0] fetch_ctl(input int p);
    return p == 0 ? F0 : p == 1 ? F1 : F2;
  endfunction
  task automatic chk(input string nm, input logic [15:0] v);
    n_chk++;
    if (act === v) n_pass++;
    else $display("FAIL %s (immediate): got %h want %h", nm, act, v);
  endtask
  task automatic cyc(input string nm, input logic [2:0] ph, input logic [8:0] ctl);
    sb.push_back('{nm, {ph, ctl, exp_hl, exp_il, exp_cnt}});
    exp_il = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input string nm, input logic [3:0] op, input logic z, input logic [35:0] ex,
                       input logic ill, input int lo3, input int lo7, input bit st7);
    logic [8:0] c;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      c = p < 4 ? fetch_ctl(p) : ex[9*(7-p) +: 9];
      if (p == 3) begin
        mem_ready = 1'b0;
        repeat (lo3) cyc(nm, 3'(p), c);
      end
      if (p == 7 && st7) begin
        mem_ready = 1'b0;
        repeat (lo7) cyc(nm, 3'(p), c);
      end
      mem_ready = !(p == 7 && !st7 && lo7 > 0);
      cyc(nm, 3'(p), c);
      mem_ready = 1'b1;
      if (p == 4 && op == 4'd0) begin
        exp_hl = 1'b1;
        return;
      end
    end
    exp_cnt++;
    exp_il = ill;
  endtask
  localparam logic [35:0] X_A   = {9'h020, 9'h080, 9'h080, 9'h082};
  localparam logic [35:0] X_HLT = {9'h030, 27'h0};
  localparam logic [35:0] X_NOP = {9'h020, 27'h0};
  initial begin
    rst_ = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    resume = 1'b0; step_mode = 1'b0; step = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_state", {3'd0, F0, 1'b0, 1'b0, 2'd0});
    cyc("reset", 3'd0, F0);
    cyc("reset", 3'd0, F0);
    rst_ = 1'b1;
    instr("lda", 4'd5, 1'b0, X_A, 1'b0, 0, 0, 1'b0);
    instr("hlt", 4'd0, 1'b0, X_HLT, 1'b0, 0, 0, 1'b0);
    cyc("halted", 3'd0, F0);
    step = 1'b1;
    cyc("halted_step_ignored", 3'd0, F0);
    step = 1'b0;
    cyc("halted", 3'd0, F0);
    resume = 1'b1;
    cyc("halted_resume", 3'd0, F0);
    resume = 1'b0;
    exp_hl = 1'b0;
    instr("sto_stall7", 4'd6, 1'b0, {9'h020, 9'h000, 9'h004, 9'h005}, 1'b0, 0, 3, 1'b1);
    chk("stall_expired", {3'd0, F0, 1'b0, 1'b0, exp_cnt});
    instr("skz_zero1", 4'd1, 1'b1, {9'h020, 9'h000, 9'h020, 9'h000}, 1'b0, 0, 0, 1'b0);
    instr("skz_zero0", 4'd1, 1'b0, X_NOP, 1'b0, 0, 0, 1'b0);
    instr("jmp_nostall", 4'd7, 1'b0, {9'h020, 9'h000, 9'h008, 9'h008}, 1'b0, 0, 1, 1'b0);
    step_mode = 1'b1;
    instr("add_stall3_step", 4'd2, 1'b0, X_A, 1'b0, 2, 0, 1'b0);
    cyc("step_wait", 3'd0, F0);
    cyc("step_wait", 3'd0, F0);
    step = 1'b1;
    cyc("step_pulse", 3'd0, F0);
    step = 1'b0;
    instr("xor_step", 4'd4, 1'b1, X_A, 1'b0, 0, 0, 1'b0);
    step_mode = 1'b0;
    cyc("step_wait_hold", 3'd0, F0);
    cyc("step_wait_hold", 3'd0, F0);
    resume = 1'b1;
    cyc("step_wait_resume", 3'd0, F0);
    resume = 1'b0;
    instr("hlt2", 4'd0, 1'b0, X_HLT, 1'b0, 0, 0, 1'b0);
    cyc("halted2", 3'd0, F0);
    resume = 1'b1;
    step   = 1'b1;
    cyc("halted_resume_step", 3'd0, F0);
    resume = 1'b0;
    step   = 1'b0;
    exp_hl = 1'b0;
    instr("illegal9", 4'd9, 1'b1, X_NOP, 1'b1, 0, 0, 1'b0);
    instr("and_after_ill", 4'd3, 1'b0, X_A, 1'b0, 0, 0, 1'b0);
    opcode = 4'd6;
    for (int p = 0; p < 5; p++) cyc("sto_abort", 3'(p), p < 4 ? fetch_ctl(p) : 9'h020);
    #2;
    rst_    = 1'b0;
    exp_cnt = 2'd0;
    #1;
    chk("async_rst_now", {3'd0, F0, 1'b0, 1'b0, 2'd0});
    cyc("async_rst_phase5", 3'd0, F0);
    cyc("rst_hold", 3'd0, F0);
    rst_ = 1'b1;
    instr("lda_after_rst", 4'd5, 1'b0, X_A, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/veririsc_sequencer.md
Name: veririsc_sequencer

Overview:
- Parametrised successor to the combinational phase decoder of the VeriRisc CPU.
- Owns the 8-phase instruction-cycle counter and the run/halt/single-step state machine.
- Inserts memory wait states, retires instructions and counts them.
- Sits between the instruction register / accumulator-zero flag and the datapath control pins.

Parameters:
- OPCODE_W, 3, opcode width; values >= 8 are illegal.
- CNT_W, 16, width of the retired-instruction counter.
- WAIT_EN, 1, 1 = honour mem_ready stalls; 0 = treat mem_ready as constant 1.

Ports:
- clk  in  1  rising-edge clock
- rst_  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  opcode from instruction register; stable from phase 4 onward
- zero  in  1  accumulator == 0
- mem_ready  in  1  memory completed the current access
- resume  in  1  one-cycle pulse; leaves HALTED
- step_mode  in  1  1 = stop after every retired instruction
- step  in  1  one-cycle pulse; leaves STEP_WAIT
- sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr  out  1 each  datapath controls
- phase  out  3  current phase 0..7
- halted  out  1  state == HALTED
- illegal  out  1  one-cycle pulse; illegal opcode retired
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- State register values: RUN, HALTED, STEP_WAIT. Phase register is 3 bits. Control outputs are decoded combinationally from (state, phase, opcode, zero).

Decode, RUN state:
- Term definitions: H = HLT, A = ADD/AND/XOR/LDA, Z = SKZ && zero, J = JMP, S = STO. An illegal opcode forces all terms to 0.
- Phase 0: sel.
- Phases 1: sel, rd.
- Phases 2–3: sel, rd, ld_ir.
- Phase 4: inc_pc, halt = H.
- Phase 5: rd = A.
- Phase 6: rd = A, inc_pc = Z, ld_pc = J, data_e = S.
- Phase 7: rd = A, ld_pc = J, data_e = S, ld_ac = A, wr = S.

Decode, other states:
- In HALTED and STEP_WAIT, all controls are 0 except sel = 1.
- phase reads 0 in both states.

Phase advance (RUN only):
- The phase increments every cycle unless stalled.
- Stall: WAIT_EN && !mem_ready in phase 3, or in phase 7 with A or S. Phase and all outputs hold while stalled, with no limit on stall length.
- Phase 4 with H: next state HALTED, phase goes to 0. inc_pc has already pulsed, so PC points past the HLT.
- Phase 7 completing (not stalled):
  - instr_count += 1 (wraps).
  - illegal pulses if opcode >= 8.
  - Phase goes to 0.
  - Next state is STEP_WAIT if step_mode, else RUN.
- A HLT instruction does not count as retired.

HALTED:
- resume → RUN, phase 0.
- step is ignored.

STEP_WAIT:
- step or resume → RUN, phase 0.
- Deasserting step_mode while in STEP_WAIT does not auto-leave the state; a pulse is still required.

Simultaneous events:
- resume and step together in HALTED: resume wins.
- step_mode only affects the next phase-7 completion.

Reset:
- rst_ low forces state RUN, phase 0, instr_count 0 immediately, also when it arrives mid-stall or mid-instruction.
- Reset output values: sel = 1; rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, halted, illegal = 0; phase = 0.

Decomposition:
- Package veririsc_pkg holds:
  - opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7;
  - the state enum (RUN, HALTED, STEP_WAIT);
  - phase constants.
- One natural sub-module: veririsc_phase_decode. It is purely combinational: (state, phase, opcode, zero) → the nine controls. It is reusable by the reference model in the bench.
- The sequential part (phase/state/counter) stays in veririsc_sequencer.

Test Plan:
1. Reset, then LDA (5), mem_ready=1:
   - phases 0..7 over 8 cycles;
   - ld_ac=1 and rd=1 in phase 7;
   - instr_count=1 afterwards.
2. HLT (0):
   - halt=1 and inc_pc=1 in phase 4;
   - halted=1 next cycle, sel=1, all other controls 0;
   - resume pulse → phase 0 next cycle; instr_count unchanged.
3. STO (6) with mem_ready low for 3 cycles in phase 7:
   - data_e=1 and wr=1 held for 4 cycles;
   - phase stays 7, then goes to 0;
   - count +1.
4. SKZ (1):
   - zero=1: inc_pc=1 in phase 6;
   - zero=0: inc_pc=0 in phase 6.
   - JMP (7): ld_pc=1 in phases 6 and 7.
5. step_mode=1, run 2 instructions:
   - STEP_WAIT after each phase 7, phase reads 0;
   - step pulse restarts;
   - resume+step together in HALTED → RUN.
6. Boundaries:
   - OPCODE_W=4, opcode=9: no datapath strobes beyond fetch; illegal pulse at phase-7 exit.
   - CNT_W=2: counter wraps 3→0.
   - rst_ asserted during phase 5: outputs return to reset values asynchronously.
